// File: rtl/mem_req_ctrl.sv
// Request controller for the 8-entry byte memory: buffers host read/write requests in a FIFO,
// issues them one at a time on registered memory pins and returns read data.
// Optional macro MEM_REQ_CTRL_ADDR_CHECK_EN adds an err output and drops out-of-range requests.
module mem_req_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DEPTH  = 8,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              enable,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    // Bad parameterisations are caught at elaboration rather than misbehaving silently.
    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
            $error("mem_req_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if ((MEM_DEPTH < 1) || ((ADDR_W < 31) && (MEM_DEPTH > (1 << ADDR_W)))) begin : g_bad_mem_depth
            $error("mem_req_ctrl: MEM_DEPTH must fit in the ADDR_W address space");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RSP
    } state_t;

    state_t              r_state;
    logic [ENTRY_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                r_enable;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_head_write;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // No bypass: a full FIFO refuses a push even when the FSM pops in the same cycle.
    assign w_push  = req_valid && !w_full;
    assign {w_head_write, w_head_addr, w_head_data} = r_fifo[r_rd_ptr];

    // The FSM consumes the head whenever it is free to start a new request.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            case (r_state)
                IDLE, WR_ISSUE: w_pop = 1'b1;
                RSP:            w_pop = rsp_ready;
                default:        w_pop = 1'b0;
            endcase
        end
    end

    // Storage has no reset so it can map onto plain RAM; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    logic w_head_bad;
    logic r_err;

    assign w_head_bad = ({1'b0, w_head_addr} >= MEM_LIMIT);
    assign err        = r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_enable    <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_enable <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
            r_err    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                WR_ISSUE: begin
                    r_state <= IDLE;
                end
                RD_ISSUE: begin
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_rsp_data  <= rdata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Issuing the popped head overrides the per-state defaults above.
            if (w_pop) begin
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
                if (w_head_bad) begin
                    r_err <= 1'b1;
                    if (w_head_write) begin
                        r_state <= IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '1;
                        r_state     <= RSP;
                    end
                end else
`endif
                if (w_head_write) begin
                    r_enable <= 1'b1;
                    r_write  <= 1'b1;
                    r_waddr  <= w_head_addr;
                    r_wdata  <= w_head_data;
                    r_state  <= WR_ISSUE;
                end else begin
                    r_enable <= 1'b1;
                    r_read   <= 1'b1;
                    r_raddr  <= w_head_addr;
                    r_state  <= RD_ISSUE;
                end
            end
        end
    end

    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state != IDLE);
    assign enable    = r_enable;
    assign read      = r_read;
    assign write     = r_write;
    assign raddr     = r_raddr;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: stimulus queues expected memory ops and read data,
// negedge monitors pop and compare them against the DUT and a behavioural 8-byte memory.
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       enable;
    logic       read;
    logic       write;
    logic [7:0] raddr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] rdata = '0;
    logic       busy;
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
    logic       err;
    int         err_cnt = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    op_t        op_q[$];
    logic [7:0] rsp_q[$];
    op_t        mon_op;
    logic [7:0] mon_rsp;

    logic [7:0] mem [8] = '{8'd40, 8'd21, 8'd17, 8'd35, 8'd44, 8'd50, 8'd61, 8'd77};

    mem_req_ctrl #(
        .FIFO_DEPTH(4),
        .MEM_DEPTH (8),
        .ADDR_W    (8),
        .DATA_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .enable   (enable),
        .read     (read),
        .write    (write),
        .raddr    (raddr),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy)
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    // Memory: writes land and reads return on the edge where the strobes are sampled.
    always @(posedge clk) begin
        if (enable && write) mem[waddr[2:0]] <= wdata;
        if (enable && read)  rdata <= mem[raddr[2:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void expect_op(input logic wr, input logic [7:0] a, input logic [7:0] d);
        op_q.push_back('{wr, a, d});
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("enable_vs_strobes", enable, read | write);
            if (enable) begin
                if (op_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got write=%0d raddr=%0d waddr=%0d, expected no strobe",
                             write, raddr, waddr);
                end else begin
                    mon_op = op_q.pop_front();
                    check("op_kind", write, mon_op.wr);
                    if (mon_op.wr) begin
                        check("op_waddr", waddr, mon_op.addr);
                        check("op_wdata", wdata, mon_op.data);
                    end else begin
                        check("op_raddr", raddr, mon_op.addr);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_data=%0d, expected no response", rsp_data);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check("rsp_data", rsp_data, mon_rsp);
                end
            end
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
            if (err) err_cnt++;
`endif
        end
    end

    // Holds the request until the DUT accepts it, then releases it just after the accept edge.
    task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int k;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("push_accepted", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"},    enable,    1'b0);
        check({tag, "_read"},      read,      1'b0);
        check({tag, "_write"},     write,     1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_raddr"},     raddr,     8'd0);
        check({tag, "_waddr"},     waddr,     8'd0);
        check({tag, "_wdata"},     wdata,     8'd0);
        check({tag, "_rsp_data"},  rsp_data,  8'd0);
        check({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int rd_cycles;
        int k;
        bit found;

        // Reset state
        idle_cycles(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Read addr 3: accept edge 0, rsp_valid first seen after edge 3
        expect_op(1'b0, 8'd3, 8'd0);
        rsp_q.push_back(8'd35);
        push(1'b0, 8'd3, 8'd0);
        lat = -1;
        rd_cycles = 0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (read) rd_cycles++;
            if (rsp_valid) begin
                lat = i;
                found = 1'b1;
            end
        end
        check("rd_latency", lat, 3);
        check("rd_strobe_cycles", rd_cycles, 1);
        idle_cycles(3);

        // Write 5 <- 99 then read 5 back
        expect_op(1'b1, 8'd5, 8'd99);
        expect_op(1'b0, 8'd5, 8'd0);
        rsp_q.push_back(8'd99);
        push(1'b1, 8'd5, 8'd99);
        push(1'b0, 8'd0 + 8'd5, 8'd0);
        idle_cycles(8);
        check("mem5_written", mem[5], 8'd99);

        // Read addr 0 stalled by rsp_ready=0 while four writes fill the FIFO
        rsp_ready = 1'b0;
        expect_op(1'b0, 8'd0, 8'd0);
        rsp_q.push_back(8'd40);
        push(1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            expect_op(1'b1, 8'(4 + i), 8'(8'hA1 + i));
            push(1'b1, 8'(4 + i), 8'(8'hA1 + i));
        end
        @(negedge clk);
        check("full_req_ready", req_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_data", rsp_data, 8'd40);
            check("stall_no_write", write, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!write && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            check("b2b_write", write, 1'b1);
            @(negedge clk);
        end
        check("b2b_write_end", write, 1'b0);
        check("b2b_busy_end", busy, 1'b0);
        check("b2b_req_ready", req_ready, 1'b1);
        idle_cycles(2);

        // Reset while in RD_WAIT with two writes queued
        expect_op(1'b0, 8'd2, 8'd0);
        push(1'b0, 8'd2, 8'd0);
        push(1'b1, 8'd1, 8'h55);
        push(1'b1, 8'd2, 8'h66);
        check("prerst_busy", busy, 1'b1);
        check("prerst_raddr", raddr, 8'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        idle_cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_rsp_valid", rsp_valid, 1'b0);
            check("postrst_enable", enable, 1'b0);
        end
        check("postrst_mem1", mem[1], 8'd21);
        idle_cycles(1);

`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
        // Out-of-range read: no strobe, one err pulse, all-ones response; next read unaffected
        err_cnt = 0;
        rsp_q.push_back(8'hFF);
        expect_op(1'b0, 8'd1, 8'd0);
        rsp_q.push_back(8'd21);
        push(1'b0, 8'd8, 8'd0);
        push(1'b0, 8'd1, 8'd0);
        idle_cycles(10);
        check("err_pulses", err_cnt, 1);
`endif

        k = 0;
        while ((op_q.size() != 0 || rsp_q.size() != 0) && k < 50) begin
            idle_cycles(1);
            k++;
        end
        check("op_queue_drained", op_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
